// File: rtl/bullet_wall_probe.sv
// bullet_wall_probe: per-frame wall probe around the live bullet.
// Reads a 1-bit tile ROM and produces registered X/Y collision flags.
module bullet_wall_probe #(
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int PROBE      = 4,
  parameter int TILE_SHIFT = 4,
  parameter int MAP_W      = 40
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        bullet_active,
  input  logic [9:0]  BulletX,
  input  logic [9:0]  BulletY,
  output logic [10:0] map_addr,
  input  logic        map_data,
  output logic        collisionX,
  output logic        collisionY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_DRAIN,
    S_UPDATE
  } state_t;

  localparam logic [10:0] PRB = 11'(PROBE);
  localparam logic [10:0] XM  = 11'(X_MAX);
  localparam logic [10:0] YM  = 11'(Y_MAX);
  localparam logic [10:0] MW  = 11'(MAP_W);
  localparam bit          W40 = (MAP_W == 40);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic [3:0]  hit_q, hit_d;
  logic        pv_q, pv_d;
  logic [1:0]  pk_q, pk_d;
  logic        poob_q, poob_d;
  logic        colx_q, colx_d;
  logic        coly_q, coly_d;

  logic [10:0] xs, ys;
  logic [10:0] row, col, rowm, addr;
  logic        oob;

  // probe coordinate and bounds check for the current index
  always_comb begin
    xs  = {1'b0, px_q};
    ys  = {1'b0, py_q};
    oob = 1'b0;
    unique case (k_q)
      2'd0: begin
        xs  = {1'b0, px_q} + PRB;
        oob = xs > XM;
      end
      2'd1: begin
        xs  = {1'b0, px_q} - PRB;
        oob = {1'b0, px_q} < PRB;
      end
      2'd2: begin
        ys  = {1'b0, py_q} + PRB;
        oob = ys > YM;
      end
      2'd3: begin
        ys  = {1'b0, py_q} - PRB;
        oob = {1'b0, py_q} < PRB;
      end
    endcase
  end

  assign row  = ys >> TILE_SHIFT;
  assign col  = xs >> TILE_SHIFT;
  assign rowm = W40 ? ((row << 5) + (row << 3))
                    : (row * MW);
  assign addr = rowm + col;

  assign map_addr = (state_q == S_PROBE && !oob)
                  ? addr : 11'd0;
  assign busy       = (state_q != S_IDLE);
  assign collisionX = colx_q;
  assign collisionY = coly_q;

  // next-state, latch, hit capture and flag update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    px_d    = px_q;
    py_d    = py_q;
    hit_d   = hit_q;
    pv_d    = 1'b0;
    pk_d    = k_q;
    poob_d  = oob;
    colx_d  = colx_q;
    coly_d  = coly_q;

    if (pv_q) begin
      hit_d[pk_q] = poob_q | map_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick && bullet_active) begin
          px_d    = BulletX;
          py_d    = BulletY;
          hit_d   = 4'b0;
          k_d     = 2'd0;
          state_d = S_PROBE;
        end else if (frame_tick) begin
          colx_d = 1'b0;
          coly_d = 1'b0;
        end
      end
      S_PROBE: begin
        pv_d = 1'b1;
        k_d  = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        colx_d  = hit_q[0] | hit_q[1];
        coly_d  = hit_q[2] | hit_q[3];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      px_q    <= 10'd0;
      py_q    <= 10'd0;
      hit_q   <= 4'b0;
      pv_q    <= 1'b0;
      pk_q    <= 2'd0;
      poob_q  <= 1'b0;
      colx_q  <= 1'b0;
      coly_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hit_q   <= hit_d;
      pv_q    <= pv_d;
      pk_q    <= pk_d;
      poob_q  <= poob_d;
      colx_q  <= colx_d;
      coly_q  <= coly_d;
    end
  end

endmodule

// File: tb/tb_bullet_wall_probe.sv
// tb_bullet_wall_probe: directed checks of the wall probe.
// A small synchronous ROM model answers map_addr one cycle later.
module tb_bullet_wall_probe;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic        bullet_active;
  logic [9:0]  BulletX;
  logic [9:0]  BulletY;
  logic [10:0] map_addr;
  logic        map_data;
  logic        collisionX;
  logic        collisionY;
  logic        busy;

  bit          rom [0:2047];
  int          checks = 0;
  int          errors = 0;

  bullet_wall_probe dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .bullet_active(bullet_active),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .collisionX   (collisionX),
    .collisionY   (collisionY),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  always_ff @(posedge Clk) begin
    map_data <= rom[map_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // tick in cycle t0, return positioned in t1
  task automatic frame(input logic [9:0] x,
                       input logic [9:0] y,
                       input logic act);
    BulletX       = x;
    BulletY       = y;
    bullet_active = act;
    frame_tick    = 1'b1;
    step();
    frame_tick    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 1'b0;
    Reset_n       = 1'b0;
    frame_tick    = 1'b0;
    bullet_active = 1'b0;
    BulletX       = 10'd0;
    BulletY       = 10'd0;
    step();
    step();
    chk("rst_cx", 32'(collisionX), 0);
    chk("rst_cy", 32'(collisionY), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(map_addr), 0);
    Reset_n = 1'b1;
    step();

    // right wall
    rom[210] = 1'b1;
    frame(10'd156, 10'd88, 1'b1);
    chk("rw_a1", 32'(map_addr), 210);
    chk("rw_b1", 32'(busy), 1);
    step();
    chk("rw_a2", 32'(map_addr), 209);
    step();
    chk("rw_a3", 32'(map_addr), 209);
    step();
    chk("rw_a4", 32'(map_addr), 209);
    step();
    chk("rw_a5", 32'(map_addr), 0);
    step();
    chk("rw_b6", 32'(busy), 1);
    chk("rw_cx6", 32'(collisionX), 0);
    step();
    chk("rw_b7", 32'(busy), 0);
    chk("rw_cx", 32'(collisionX), 1);
    chk("rw_cy", 32'(collisionY), 0);

    // inactive bullet
    frame(10'd156, 10'd88, 1'b0);
    chk("ia_cx", 32'(collisionX), 0);
    chk("ia_cy", 32'(collisionY), 0);
    for (int i = 0; i < 6; i++) begin
      chk("ia_busy", 32'(busy), 0);
      chk("ia_addr", 32'(map_addr), 0);
      step();
    end

    // left screen edge, empty map
    rom[210] = 1'b0;
    frame(10'd2, 10'd200, 1'b1);
    chk("le_a1", 32'(map_addr), 480);
    step();
    chk("le_a2", 32'(map_addr), 0);
    step();
    chk("le_a3", 32'(map_addr), 480);
    for (int i = 0; i < 4; i++) step();
    chk("le_cx", 32'(collisionX), 1);
    chk("le_cy", 32'(collisionY), 0);

    // bottom-right corner
    frame(10'd639, 10'd479, 1'b1);
    chk("br_a1", 32'(map_addr), 0);
    step();
    chk("br_a2", 32'(map_addr), 1199);
    step();
    chk("br_a3", 32'(map_addr), 0);
    step();
    chk("br_a4", 32'(map_addr), 1199);
    for (int i = 0; i < 3; i++) step();
    chk("br_cx", 32'(collisionX), 1);
    chk("br_cy", 32'(collisionY), 1);

    // tick during busy, position changes after latch
    rom[210] = 1'b1;
    frame(10'd300, 10'd300, 1'b1);
    step();
    step();
    frame_tick = 1'b1;
    BulletX    = 10'd156;
    BulletY    = 10'd88;
    step();
    frame_tick = 1'b0;
    chk("tb_a4", 32'(map_addr), 738);
    step();
    step();
    chk("tb_b6", 32'(busy), 1);
    step();
    chk("tb_b7", 32'(busy), 0);
    chk("tb_cx", 32'(collisionX), 0);
    chk("tb_cy", 32'(collisionY), 0);
    step();
    chk("tb_b8", 32'(busy), 0);
    chk("tb_a8", 32'(map_addr), 0);

    // set flags, then reset mid-probe
    frame(10'd156, 10'd88, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("mr_pre", 32'(collisionX), 1);
    frame(10'd639, 10'd479, 1'b1);
    step();
    step();
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    chk("mr_cx", 32'(collisionX), 0);
    chk("mr_cy", 32'(collisionY), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_addr", 32'(map_addr), 0);
    step();
    frame(10'd156, 10'd88, 1'b1);
    chk("mr_a1", 32'(map_addr), 210);
    for (int i = 0; i < 5; i++) step();
    chk("mr_b6", 32'(busy), 1);
    step();
    chk("mr_b7", 32'(busy), 0);
    chk("mr_cx2", 32'(collisionX), 1);
    chk("mr_cy2", 32'(collisionY), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
